s1_fetch: RTL and testbench
===========================

// Module: s1_fetch
// PURPOSE
//  Stage-1 fetch of the 3-stage RV32I core: owns the PC, drives the synchronous-read BIOS/IMEM
//  address ports and presents the fetched instruction to s2_control/datapath as instruction_s2.
//  A static BTFN predictor (backward branch / JAL taken) steers the next fetch. Mispredict
//  redirects come back registered from stage 3; the wrong-path instruction becomes a NOP bubble.
// PARAMETERS
//  RESET_PC   32'h4000_0000  first fetch address after reset (BIOS)
//  NOP        32'h0000_0013  addi x0,x0,0 injected on bubbles
//  BIOS_AW    12             BIOS word-address width
//  IMEM_AW    14             IMEM word-address width
// PORTS
//  clk              in   1        core clock
//  rst_n            in   1        asynchronous, active-low reset
//  stall_i          in   1        hold: s2 instruction and PC frozen this cycle
//  mispredict_i     in   1        stage 3 found wrong next-PC (branch/JALR); registered upstream
//  correct_pc_i     in   32       true next PC, valid with mispredict_i
//  bios_addr        out  BIOS_AW  BIOS word address = next_pc[BIOS_AW+1:2]
//  imem_addr        out  IMEM_AW  IMEM word address = next_pc[IMEM_AW+1:2]
//  bios_dout        in   32       BIOS data, one cycle after address
//  imem_dout        in   32       IMEM data, one cycle after address
//  pc_s2            out  32       PC of instruction_s2
//  instruction_s2   out  32       instruction entering stage 2 (NOP when !valid_s2)
//  valid_s2         out  1        instruction_s2 is a real, on-path instruction
//  pred_taken_s2    out  1        fetch redirected after instruction_s2 (carried down for check)
//  fetch_cnt        out  32       count of delivered valid instructions
//  mispred_cnt      out  32       count of accepted mispredict redirects
// BEHAVIOUR
//  State: pc_q (PC whose data is on dout this cycle), kill_q (dout invalid), two counters.
//  Reset (rst_n=0, async): pc_q=RESET_PC, kill_q=1, counters=0; outputs: pc_s2=RESET_PC,
//   instruction_s2=NOP, valid_s2=0, pred_taken_s2=0, addresses = RESET_PC word.
//  Source mux: raw = pc_q[30] ? bios_dout : imem_dout (select from pc_q, never next_pc).
//  valid_s2 = !kill_q && !mispredict_i; instruction_s2 = valid_s2 ? raw : NOP; pc_s2 = pc_q.
//  Predict (on raw, only when valid_s2): BRANCH with imm_b[31]=1 -> pc_q+imm_b;
//   JAL -> pc_q+imm_j; else pc_q+4. JALR always predicted not-taken (pc_q+4).
//   imm_b={{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}; imm_j={{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}.
//   All adds 32-bit modulo 2^32 (wrap silently).
//  next_pc priority: mispredict_i -> correct_pc_i; kill_q -> pc_q (re-read);
//   stall_i -> pc_q (re-read keeps dout stable); predicted target; pc_q+4.
//  Edge: pc_q<=next_pc; kill_q<=0 (only reset sets it). pred_taken_s2 = valid_s2 && target taken.
//  Latency: 1 cycle address->instruction_s2; mispredict penalty exactly 1 bubble.
//  Simultaneous mispredict_i+stall_i: mispredict wins (stalled instr is wrong-path, killed).
//  Counters: fetch_cnt++ when valid_s2 && !stall_i; mispred_cnt++ when mispredict_i; both wrap.
//  Reset asserted mid-run: all state returns to reset values immediately, fetch restarts at RESET_PC.
//  First cycle after release: bubble (kill_q=1), RESET_PC re-presented; real instr next cycle.
// STRUCTURE
//  Opcode/funct macros (OPC_BRANCH, OPC_JAL, OPC_JALR) from the shared opcode header; NOP and
//  RESET_PC defaults added there as shared constants. One natural sub-module: s1_btfn_predict
//  (combinational: raw, pc_q -> taken, target). PC/kill/counter registers stay in s1_fetch.
// TESTING
//  Reset release, BIOS = sequential addis -> cycle0 NOP/valid 0, then pc_s2 4000_0000, _0004, _0008.
//  pc_q=4000_0010 holds beq imm=-8 -> next addr word of 4000_0008, pred_taken_s2=1, no bubble.
//  Forward bne imm=+16 at 0000_0100 then mispredict_i, correct_pc_i=0000_0110 -> one NOP, then pc_s2=0000_0110, mispred_cnt=1.
//  stall_i high 3 cycles -> instruction_s2/pc_s2 constant, fetch_cnt unchanged; resumes pc+4.
//  mispredict_i with stall_i same cycle -> bubble, redirect taken, stall ignored.
//  rst_n pulsed low mid-stream (async, off-edge) -> outputs reset instantly; restart at 4000_0000.

Source files
------------

// File: rtl/s1_fetch_pkg.sv
// Shared constants and immediate decoders for the stage-1 fetch unit.
package s1_fetch_pkg;

    localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [6:0]  OPC_JALR     = 7'b1100111;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/s1_btfn_predict.sv
// Static BTFN predictor: backward conditional branches and JAL are taken, all else falls through.
module s1_btfn_predict
    import s1_fetch_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        taken  = 1'b0;
        target = pc + 32'd4;
        case (raw[6:0])
            OPC_BRANCH: begin
                if (raw[31]) begin
                    taken  = 1'b1;
                    target = pc + imm_b(raw);
                end
            end
            OPC_JAL: begin
                taken  = 1'b1;
                target = pc + imm_j(raw);
            end
            // Register target unknown at fetch; stage 3 repairs it via mispredict.
            OPC_JALR: taken = 1'b0;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/s1_fetch.sv
// Stage-1 fetch: PC register, synchronous-read BIOS/IMEM addressing, BTFN steering and
// single-bubble recovery from stage-3 redirects.
module s1_fetch
    import s1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_INSTR,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               mispredict_i,
    input  logic [31:0]        correct_pc_i,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        bios_dout,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        pc_s2,
    output logic [31:0]        instruction_s2,
    output logic               valid_s2,
    output logic               pred_taken_s2,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        mispred_cnt
);

    logic [31:0] pc_reg;
    logic        kill_reg;
    logic [31:0] fetch_cnt_reg;
    logic [31:0] mispred_cnt_reg;
    logic [31:0] pc_next;
    logic [31:0] raw;
    logic        pred_hit;
    logic [31:0] pred_target;

    // Data on dout belongs to pc_reg, so the source select must follow pc_reg.
    assign raw = pc_reg[30] ? bios_dout : imem_dout;

    s1_btfn_predict u_predict (
        .raw    (raw),
        .pc     (pc_reg),
        .taken  (pred_hit),
        .target (pred_target)
    );

    assign valid_s2       = !kill_reg && !mispredict_i;
    assign instruction_s2 = valid_s2 ? raw : NOP;
    assign pc_s2          = pc_reg;
    assign pred_taken_s2  = valid_s2 && pred_hit;
    assign fetch_cnt      = fetch_cnt_reg;
    assign mispred_cnt    = mispred_cnt_reg;

    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (mispredict_i) begin
            pc_next = correct_pc_i;
        end else if (kill_reg || stall_i) begin
            // Re-reading the same address keeps dout stable for the held instruction.
            pc_next = pc_reg;
        end else if (pred_taken_s2) begin
            pc_next = pred_target;
        end
    end

    assign bios_addr = pc_next[BIOS_AW+1:2];
    assign imem_addr = pc_next[IMEM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            kill_reg        <= 1'b1;
            fetch_cnt_reg   <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else begin
            pc_reg   <= pc_next;
            kill_reg <= 1'b0;
            if (valid_s2 && !stall_i) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (mispredict_i) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_s1_fetch.sv
// Self-checking bench for s1_fetch: directed scenarios plus randomized stall/redirect traffic
// compared against a program-flow reference model.
module tb_s1_fetch;

    localparam logic [31:0] RPC  = 32'h4000_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        mispredict_i = 1'b0;
    logic [31:0] correct_pc_i = 32'd0;
    logic [11:0] bios_addr;
    logic [13:0] imem_addr;
    logic [31:0] bios_dout = 32'd0;
    logic [31:0] imem_dout = 32'd0;
    logic [31:0] pc_s2, instruction_s2, fetch_cnt, mispred_cnt;
    logic        valid_s2, pred_taken_s2;

    s1_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .mispredict_i   (mispredict_i),
        .correct_pc_i   (correct_pc_i),
        .bios_addr      (bios_addr),
        .imem_addr      (imem_addr),
        .bios_dout      (bios_dout),
        .imem_dout      (imem_dout),
        .pc_s2          (pc_s2),
        .instruction_s2 (instruction_s2),
        .valid_s2       (valid_s2),
        .pred_taken_s2  (pred_taken_s2),
        .fetch_cnt      (fetch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] bios_mem [0:4095];
    logic [31:0] imem_mem [0:16383];

    always @(posedge clk) begin
        bios_dout <= bios_mem[bios_addr];
        imem_dout <= imem_mem[imem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: program counter flow at the instruction level.
    logic [31:0] m_pc, m_fc, m_mc;
    bit          m_kill;
    logic        e_valid, e_pt;
    logic [31:0] e_instr, e_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a[30] ? bios_mem[a[13:2]] : imem_mem[a[15:2]];
    endfunction

    function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rd);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'h6f};
    endfunction

    task automatic predict(input logic [31:0] pc, input logic [31:0] ins,
                           output bit tk, output logic [31:0] tgt);
        int off;
        tk  = 0;
        tgt = pc + 32'd4;
        if (ins[6:0] == 7'h63) begin
            off = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            if (off < 0) begin
                tk  = 1;
                tgt = pc + off;
            end
        end else if (ins[6:0] == 7'h6f) begin
            off = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            tk  = 1;
            tgt = pc + off;
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_kill = 1; m_fc = 0; m_mc = 0;
    endtask

    task automatic drive(input bit st, input bit mis, input logic [31:0] cpc);
        bit          tk;
        logic [31:0] tgt;
        stall_i = st; mispredict_i = mis; correct_pc_i = cpc;
        #1;
        predict(m_pc, mem_word(m_pc), tk, tgt);
        e_valid = !m_kill && !mis;
        e_instr = e_valid ? mem_word(m_pc) : NOPI;
        e_pt    = e_valid && tk;
        if (mis)              e_next = cpc;
        else if (m_kill || st) e_next = m_pc;
        else if (e_pt)        e_next = tgt;
        else                  e_next = m_pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_valid && !stall_i) m_fc = m_fc + 1;
        if (mispredict_i) m_mc = m_mc + 1;
        m_pc = e_next;
        m_kill = 0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] want_pc [4];
        want_pc = '{RPC, RPC, RPC + 32'd4, RPC + 32'd8};
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (pc_s2 !== RPC || valid_s2 !== 1'b0 || instruction_s2 !== NOPI || pred_taken_s2 !== 1'b0
            || fetch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || bios_addr !== RPC[13:2]) begin
            errors++;
            $display("FAIL reset_state: pc=%h valid=%b instr=%h pt=%b fc=%0d mc=%0d ba=%h want pc=%h NOP valid 0",
                     pc_s2, valid_s2, instruction_s2, pred_taken_s2, fetch_cnt, mispred_cnt, bios_addr, RPC);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 32'd0);
            checks++;
            if (pc_s2 !== want_pc[c] || valid_s2 !== (c != 0) || instruction_s2 !== e_instr) begin
                errors++;
                $display("FAIL release_cycle%0d: pc=%h valid=%b instr=%h want pc=%h valid=%b instr=%h",
                         c, pc_s2, valid_s2, instruction_s2, want_pc[c], (c != 0), e_instr);
            end
            $display("reset release cycle %0d: pc_s2=%h valid=%b", c, pc_s2, valid_s2);
            tick();
        end
    endtask

    task automatic test_backward_branch();
        drive(0, 0, 32'd0);
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h4000_0010 || pred_taken_s2 !== 1'b1 || bios_addr !== 12'd2) begin
            errors++;
            $display("FAIL backward_beq: pc=%h pt=%b bios_addr=%h want 40000010 1 002",
                     pc_s2, pred_taken_s2, bios_addr);
        end
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h4000_0008 || valid_s2 !== 1'b1) begin
            errors++;
            $display("FAIL backward_target: pc=%h valid=%b want 40000008 1", pc_s2, valid_s2);
        end
        $display("backward branch: target pc_s2=%h valid=%b", pc_s2, valid_s2);
        tick();
    endtask

    task automatic test_mispredict();
        drive(0, 1, 32'h0000_0100);
        checks++;
        if (valid_s2 !== 1'b0 || instruction_s2 !== NOPI || imem_addr !== 14'h40) begin
            errors++;
            $display("FAIL redirect_bubble: valid=%b instr=%h imem_addr=%h want 0 NOP 0040",
                     valid_s2, instruction_s2, imem_addr);
        end
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h100 || valid_s2 !== 1'b1 || pred_taken_s2 !== 1'b0 || instruction_s2 !== enc_b(16, 3'b001)) begin
            errors++;
            $display("FAIL forward_bne: pc=%h valid=%b pt=%b instr=%h want 00000100 1 0 %h",
                     pc_s2, valid_s2, pred_taken_s2, instruction_s2, enc_b(16, 3'b001));
        end
        tick();
        drive(0, 1, 32'h0000_0110);
        checks++;
        if (valid_s2 !== 1'b0 || instruction_s2 !== NOPI) begin
            errors++;
            $display("FAIL mispredict_bubble: valid=%b instr=%h want 0 NOP", valid_s2, instruction_s2);
        end
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h110 || valid_s2 !== 1'b1 || mispred_cnt !== 32'd2) begin
            errors++;
            $display("FAIL mispredict_recover: pc=%h valid=%b mc=%0d want 00000110 1 2",
                     pc_s2, valid_s2, mispred_cnt);
        end
        $display("mispredict: pc_s2=%h mispred_cnt=%0d", pc_s2, mispred_cnt);
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] fc0;
        fc0 = m_fc;
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 32'd0);
            checks++;
            if (pc_s2 !== 32'h114 || instruction_s2 !== imem_mem[69] || fetch_cnt !== fc0) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h instr=%h fc=%0d want 00000114 %h %0d",
                         c, pc_s2, instruction_s2, fetch_cnt, imem_mem[69], fc0);
            end
            tick();
        end
        drive(0, 0, 32'd0);
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h118 || valid_s2 !== 1'b1 || fetch_cnt !== fc0 + 32'd1) begin
            errors++;
            $display("FAIL stall_resume: pc=%h valid=%b fc=%0d want 00000118 1 %0d",
                     pc_s2, valid_s2, fetch_cnt, fc0 + 1);
        end
        $display("stall: resumed pc_s2=%h fetch_cnt=%0d", pc_s2, fetch_cnt);
        tick();
    endtask

    task automatic test_mispredict_stall();
        drive(1, 1, 32'h0000_0200);
        checks++;
        if (valid_s2 !== 1'b0 || instruction_s2 !== NOPI || imem_addr !== 14'h80) begin
            errors++;
            $display("FAIL mis_stall_bubble: valid=%b instr=%h imem_addr=%h want 0 NOP 0080",
                     valid_s2, instruction_s2, imem_addr);
        end
        tick();
        drive(0, 0, 32'd0);
        checks++;
        if (pc_s2 !== 32'h200 || valid_s2 !== 1'b1) begin
            errors++;
            $display("FAIL mis_stall_redirect: pc=%h valid=%b want 00000200 1", pc_s2, valid_s2);
        end
        $display("mispredict+stall: pc_s2=%h", pc_s2);
        tick();
    endtask

    task automatic test_async_reset();
        drive(0, 0, 32'd0);
        tick();
        stall_i = 1'b0; mispredict_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc_s2 !== RPC || valid_s2 !== 1'b0 || instruction_s2 !== NOPI || fetch_cnt !== 32'd0
            || mispred_cnt !== 32'd0 || bios_addr !== RPC[13:2]) begin
            errors++;
            $display("FAIL async_reset: pc=%h valid=%b instr=%h fc=%0d mc=%0d ba=%h",
                     pc_s2, valid_s2, instruction_s2, fetch_cnt, mispred_cnt, bios_addr);
        end
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 32'd0);
            checks++;
            if (pc_s2 !== (c == 2 ? RPC + 32'd4 : RPC) || valid_s2 !== (c != 0)) begin
                errors++;
                $display("FAIL restart_cycle%0d: pc=%h valid=%b", c, pc_s2, valid_s2);
            end
            tick();
        end
        $display("async reset: restarted at %h", RPC);
    endtask

    task automatic test_random();
        bit          st, mis;
        logic [31:0] cpc;
        for (int c = 0; c < 400; c++) begin
            st  = ($urandom_range(0, 4) == 0);
            mis = ($urandom_range(0, 9) == 0);
            cpc = {1'b0, 1'($urandom_range(0, 1)), 14'd0, 14'($urandom), 2'b00};
            drive(st, mis, cpc);
            checks++;
            if (pc_s2 !== m_pc || instruction_s2 !== e_instr || valid_s2 !== e_valid || pred_taken_s2 !== e_pt
                || bios_addr !== e_next[13:2] || imem_addr !== e_next[15:2]
                || fetch_cnt !== m_fc || mispred_cnt !== m_mc) begin
                errors++;
                $display("FAIL random%0d: pc=%h/%h instr=%h/%h v=%b/%b pt=%b/%b ba=%h/%h ia=%h/%h fc=%0d/%0d mc=%0d/%0d",
                         c, pc_s2, m_pc, instruction_s2, e_instr, valid_s2, e_valid, pred_taken_s2, e_pt,
                         bios_addr, e_next[13:2], imem_addr, e_next[15:2], fetch_cnt, m_fc, mispred_cnt, m_mc);
            end
            $display("random %0d: st=%b mis=%b pc_s2=%h valid=%b pt=%b", c, st, mis, pc_s2, valid_s2, pred_taken_s2);
            tick();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 9))
            6, 7:    return enc_b(2 * ($urandom_range(0, 64) - 32), 3'($urandom_range(0, 7)));
            8:       return enc_j(4 * ($urandom_range(0, 64) - 32));
            9:       return {12'($urandom), 5'd1, 3'b000, 5'd1, 7'h67};
            default: return enc_addi(12'($urandom), 5'($urandom));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++)  bios_mem[i] = (i < 16) ? enc_addi(12'(i), 5'd1) : rand_instr();
        for (int i = 0; i < 16384; i++) imem_mem[i] = rand_instr();
        for (int i = 64; i < 160; i++)  imem_mem[i] = enc_addi(12'(i), 5'd2);
        bios_mem[4]  = enc_b(-8, 3'b000);
        imem_mem[64] = enc_b(16, 3'b001);
        model_reset();

        test_reset();
        test_backward_branch();
        test_mispredict();
        test_stall();
        test_mispredict_stall();
        test_async_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
